lbus_initiator: RTL
===================

// Module: lbus_initiator
// PURPOSE
//  Synchronous local-bus master; drives nADS/LA/LD/WnR/nCS2/nCS3/nRD/nWR and consumes nREADY/nBTERM, i.e. the initiator end of
//  the SURF register/HK/LAB local bus. Turns a request (space, word address, length, direction) into single or burst beats and
//  re-issues nADS whenever the target asserts nBTERM. Used on the controller side and as a synthesizable bus driver on test boards.
// PARAMETERS
//  LEN_W      4    request length width; beats = req_len_i+1 (1..16)
//  TIMEOUT    64   max cycles waiting for nREADY per beat before abort
// PORTS
//  clk_i        in   1   bus clock (same clock as target)
//  rst_i        in   1   asynchronous, active-high reset
//  req_valid_i  in   1   request strobe; accepted when req_ready_o=1
//  req_ready_o  out  1   high only in IDLE
//  req_write_i  in   1   1=write, 0=read
//  req_space_i  in   2   0=REG (nCS2=nCS3=1), 1=HK (nCS2=0), 2=LAB (nCS3=0), 3=illegal->err
//  req_addr_i   in   6   start word address (LA[7:2])
//  req_len_i    in   LEN_W  beats-1
//  wr_dat_i     in   32  write data for current beat (first-word-fall-through source)
//  wr_pop_o     out  1   1-cycle pulse: wr_dat_i consumed
//  rd_dat_o     out  32  read data
//  rd_valid_o   out  1   1-cycle pulse per read beat
//  done_o       out  1   1-cycle pulse at end of request
//  err_o        out  1   with done_o: timeout or illegal space
//  nADS,WnR,nCS2,nCS3,nRD,nWR  out 1  bus controls; WnR=1 means write
//  LA           out  6   word address
//  LD           inout 32 data; driven only for write data beats
//  nREADY,nBTERM in  1   target handshakes, sampled on rising clk_i
// BEHAVIOUR
//  Reset: nADS,nCS2,nCS3,nRD,nWR=1; WnR=0; LA=0; LD=Z; req_ready_o=1; all pulses 0; rd_dat_o=0; FSM=IDLE; counters 0.
//  Illegal space at accept -> next cycle done_o=err_o=1, no bus activity.
//  FSM: IDLE -> ADDR (accept) -> DATA -> {ADDR | RECOV} ; RECOV -> IDLE.
//  ADDR (1 cycle): nADS=0, LA=cur_addr, nCS*/WnR per request (held through DATA), nRD/nWR=1.
//  DATA: nRD=0 (read) or nWR=0 and LD=wr_dat_i (write); timeout counter clears on entry, increments each cycle.
//  Beat completes on a cycle where sampled nREADY=0: read -> rd_dat_o<=LD, rd_valid_o=1 next cycle; write -> wr_pop_o=1 same
//  cycle; cur_addr+=1 (6-bit wrap 63->0), remaining-=1.
//  After a completing beat: remaining==0 -> RECOV; else if nBTERM sampled 0 -> ADDR (new nADS at cur_addr); else stay DATA.
//  nBTERM with no nREADY is ignored. nRD/nWR deassert for the ADDR cycle between re-issued beats.
//  Timeout: counter reaches TIMEOUT-1 without nREADY -> RECOV with err latched; no further beats.
//  RECOV (1 cycle): all controls deasserted, LD=Z, done_o=1, err_o=latched err; then IDLE. Minimum 1 idle cycle between requests.
//  LD output enable drops to Z in the same cycle nWR deasserts; never driven during reads.
//  Reset mid-transfer: controls return to reset values asynchronously, no done_o.
// STRUCTURE
//  lbus_pkg: space encodings, FSM state enum (IDLE,ADDR,DATA,RECOV), default LEN_W/TIMEOUT.
//  One sub-module natural: lbus_beat_timer (clear/enable/expire counter); remainder inline.
//  All bus outputs and LD input registered in IOBs; LD tristate per bit.
// TESTING
//  REG read, addr 0, len 0; target returns 0x53555246 with nREADY 2 cycles after nADS, nBTERM=0 -> rd_dat_o=0x53555246, done_o, err_o=0.
//  HK write addr 5, len 0, data 0x0000ABCD -> nCS2=0, WnR=1, LD=0xABCD while nWR=0, one wr_pop_o.
//  LAB burst read addr 62, len 3, target bursting (nBTERM=1) -> one nADS, 4 rd_valid_o, LA sequence 62,63,0,1.
//  LAB read len 3, target asserts nBTERM every beat -> 4 nADS pulses at LA 0,1,2,3; 4 rd_valid_o.
//  No nREADY with TIMEOUT=8 -> bus released after 8 DATA cycles, done_o=err_o=1; space=3 -> immediate err, no nADS.
//  rst_i pulsed mid-burst -> outputs at reset values same cycle, no done_o; next request completes normally.

Source files
------------

// File: rtl/lbus_pkg.sv
// lbus_pkg: shared definitions for the local-bus initiator.
//  - address-space encodings carried on req_space_i
//  - initiator FSM state enum
//  - default length width and per-beat ready timeout
//  - helper mapping a space to its active-low chip selects
package lbus_pkg;

  localparam int unsigned LBUS_LEN_W_DEF   = 4;
  localparam int unsigned LBUS_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    SPACE_REG = 2'd0,
    SPACE_HK  = 2'd1,
    SPACE_LAB = 2'd2,
    SPACE_BAD = 2'd3
  } lbus_space_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RECOV
  } lbus_state_e;

  // Returns {nCS3, nCS2} for a legal space; REG leaves both deasserted.
  function automatic logic [1:0] space_cs(input logic [1:0] sp);
    logic [1:0] cs;
    cs = 2'b11;
    case (sp)
      SPACE_HK:  cs = 2'b10;
      SPACE_LAB: cs = 2'b01;
      default:   cs = 2'b11;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/lbus_beat_timer.sv
// lbus_beat_timer: per-beat wait counter.
//  clk_i    in  bus clock
//  rst_i    in  asynchronous active-high reset
//  clr_i    in  synchronous clear (wins over enable)
//  en_i     in  count one cycle; holds once expired
//  expire_o out high while the count equals TIMEOUT-1
module lbus_beat_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/lbus_initiator.sv
// lbus_initiator: synchronous local-bus master (initiator end of the
// register/HK/LAB bus). Converts a request into single or burst beats and
// re-issues nADS whenever the target terminates a burst with nBTERM.
//  Request side : req_valid_i/req_ready_o, req_write_i, req_space_i,
//                 req_addr_i (word address), req_len_i (beats-1)
//  Write data   : wr_dat_i (first-word-fall-through), wr_pop_o consume pulse
//  Read data    : rd_dat_o, rd_valid_o pulse per beat
//  Status       : done_o pulse at end of request, err_o with it on
//                 timeout or illegal space
//  Bus          : nADS, WnR, nCS2, nCS3, nRD, nWR, LA[5:0], LD[31:0] (inout),
//                 nREADY, nBTERM (sampled on rising clk_i)
module lbus_initiator
  import lbus_pkg::*;
#(
  parameter int unsigned LEN_W   = LBUS_LEN_W_DEF,
  parameter int unsigned TIMEOUT = LBUS_TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [1:0]       req_space_i,
  input  logic [5:0]       req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [31:0]      wr_dat_i,
  output logic             wr_pop_o,
  output logic [31:0]      rd_dat_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic             err_o,
  output logic             nADS,
  output logic             WnR,
  output logic             nCS2,
  output logic             nCS3,
  output logic             nRD,
  output logic             nWR,
  output logic [5:0]       LA,
  inout  wire  [31:0]      LD,
  input  logic             nREADY,
  input  logic             nBTERM
);

  lbus_state_e      state_q;
  logic [5:0]       la_q;
  logic [LEN_W-1:0] rem_q;
  logic             write_q;
  logic             nads_q, wnr_q, ncs2_q, ncs3_q, nrd_q, nwr_q, oe_q;
  logic [31:0]      rd_dat_q;
  logic             rd_valid_q, done_q, err_q;
  logic             beat_done, expire;

  assign beat_done = (state_q == ST_DATA) && !nREADY;

  lbus_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    ((state_q == ST_ADDR) || beat_done),
    .en_i     (state_q == ST_DATA),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      la_q       <= '0;
      rem_q      <= '0;
      write_q    <= 1'b0;
      nads_q     <= 1'b1;
      wnr_q      <= 1'b0;
      ncs2_q     <= 1'b1;
      ncs3_q     <= 1'b1;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      oe_q       <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            la_q    <= req_addr_i;
            rem_q   <= req_len_i;
            write_q <= req_write_i;
            if (req_space_i == SPACE_BAD) begin
              state_q <= ST_RECOV;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q          <= ST_ADDR;
              nads_q           <= 1'b0;
              wnr_q            <= req_write_i;
              {ncs3_q, ncs2_q} <= space_cs(req_space_i);
            end
          end
        end
        ST_ADDR: begin
          state_q <= ST_DATA;
          nads_q  <= 1'b1;
          nrd_q   <= write_q;
          nwr_q   <= !write_q;
          oe_q    <= write_q;
        end
        ST_DATA: begin
          if (!nREADY) begin
            if (!write_q) begin
              rd_dat_q   <= LD;
              rd_valid_q <= 1'b1;
            end
            la_q <= la_q + 1'b1;
            if (rem_q == '0) begin
              state_q <= ST_RECOV;
              done_q  <= 1'b1;
              nads_q  <= 1'b1;
              wnr_q   <= 1'b0;
              ncs2_q  <= 1'b1;
              ncs3_q  <= 1'b1;
              nrd_q   <= 1'b1;
              nwr_q   <= 1'b1;
              oe_q    <= 1'b0;
            end else begin
              rem_q <= rem_q - 1'b1;
              // Burst terminated by the target: restart with a fresh address phase.
              if (!nBTERM) begin
                state_q <= ST_ADDR;
                nads_q  <= 1'b0;
                nrd_q   <= 1'b1;
                nwr_q   <= 1'b1;
                oe_q    <= 1'b0;
              end
            end
          end else if (expire) begin
            state_q <= ST_RECOV;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            nads_q  <= 1'b1;
            wnr_q   <= 1'b0;
            ncs2_q  <= 1'b1;
            ncs3_q  <= 1'b1;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            oe_q    <= 1'b0;
          end
        end
        ST_RECOV: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write data is first-word-fall-through: the pop and the LD value follow the
  // source directly so the next word is on the bus in the cycle after a pop.
  assign wr_pop_o = beat_done && write_q;
  assign LD       = oe_q ? wr_dat_i : 'z;

  assign req_ready_o = (state_q == ST_IDLE);
  assign rd_dat_o    = rd_dat_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign nADS        = nads_q;
  assign WnR         = wnr_q;
  assign nCS2        = ncs2_q;
  assign nCS3        = ncs3_q;
  assign nRD         = nrd_q;
  assign nWR         = nwr_q;
  assign LA          = la_q;

endmodule
